// File: rtl/ram_loader_pkg.sv
// Shared types for the rv32i RAM port and the boot-time program loader.
package ram_loader_pkg;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } mem_op_e;

  typedef enum logic [1:0] {
    RAM_MASK_B = 2'd0,
    RAM_MASK_H = 2'd1,
    RAM_MASK_W = 2'd2
  } ram_mask_e;

  typedef enum logic [1:0] {
    HOLD,
    LOAD,
    DRAIN,
    RUN
  } loader_state_e;

  localparam int LOADER_FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/ram_loader_fifo.sv
// Small synchronous FIFO buffering bridge writes; head is the oldest entry, valid when not empty.
module ram_loader_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 51
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]   wr_q, wr_d, rd_q, rd_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_q[PTR_W-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[PTR_W-1:0]] <= din_i;
  end

endmodule

// File: rtl/ram_loader.sv
// Boot loader owning RAM port 1: stores bridge words while the CPU is held, then passes the CPU through.
// Optional macro RAM_LOADER_BSWAP_EN byte-reverses bridge data before it is queued.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          ADDR_LENGTH = 21,
  parameter int          FIFO_DEPTH  = LOADER_FIFO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        load_end,
  input  logic        bridge_wr,
  input  logic [31:0] bridge_addr,
  input  logic [31:0] bridge_wdata,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  mem_op_e     cpu_mem_op,
  input  ram_mask_e   cpu_ram_mask,
  output logic [31:0] ram_addr1,
  output logic [31:0] ram_wdata,
  output mem_op_e     ram_mem_op,
  output ram_mask_e   ram_ram_mask,
  output logic        cpu_hold,
  output logic        busy,
  output logic        overflow,
  output logic [31:0] words_written
);
  localparam int WA_W  = ADDR_LENGTH - 2;
  localparam int ENT_W = WA_W + 32;

  function automatic logic [31:0] load_data(input logic [31:0] d);
`ifdef RAM_LOADER_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  loader_state_e    state_q, state_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      words_q, words_d;
  mem_op_e          op_q;
  logic [31:0]      addr_q, wdata_q;
  logic [31:0]      offset;
  logic             in_window, push_req, pop, drop;
  logic             fifo_push, fifo_pop, empty, full;
  logic [ENT_W-1:0] push_ent, head, store_ent;

  assign offset    = bridge_addr - ADDR_BASE;
  assign in_window = (bridge_addr >= ADDR_BASE) && ((offset >> ADDR_LENGTH) == 32'd0);
  assign push_req  = (state_q == LOAD) && bridge_wr && in_window;
  assign push_ent  = {offset[ADDR_LENGTH-1:2], load_data(bridge_wdata)};

  // A write arriving at an empty FIFO bypasses it straight into the store register.
  assign pop       = !empty || push_req;
  assign fifo_pop  = pop && !empty;
  assign fifo_push = push_req && (empty ? !pop : (!full || pop));
  assign drop      = push_req && full && !pop;
  assign store_ent = empty ? push_ent : head;

  ram_loader_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WIDTH     (ENT_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (fifo_push),
    .pop_i  (fifo_pop),
    .din_i  (push_ent),
    .full_o (full),
    .empty_o(empty),
    .head_o (head)
  );

  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    words_d    = words_q;
    if (pop)  words_d    = words_q + 32'd1;
    if (drop) overflow_d = 1'b1;
    case (state_q)
      HOLD: begin
        if (load_start) begin
          state_d    = LOAD;
          words_d    = 32'd0;
          overflow_d = 1'b0;
        end else if (load_end) begin
          state_d = RUN;
        end
      end
      LOAD:  if (load_end) state_d = DRAIN;
      DRAIN: if (empty && !pop && op_q != MEM_STORE) state_d = RUN;
      RUN: begin
        if (load_start) begin
          state_d    = LOAD;
          words_d    = 32'd0;
          overflow_d = 1'b0;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HOLD;
      overflow_q <= 1'b0;
      words_q    <= 32'd0;
      op_q       <= MEM_LOAD;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      words_q    <= words_d;
      op_q       <= pop ? MEM_STORE : MEM_LOAD;
      if (pop) begin
        addr_q  <= 32'({store_ent[ENT_W-1:32], 2'b00});
        wdata_q <= store_ent[31:0];
      end
    end
  end

  always_comb begin
    ram_addr1    = addr_q;
    ram_wdata    = wdata_q;
    ram_mem_op   = op_q;
    ram_ram_mask = RAM_MASK_W;
    if (state_q == RUN) begin
      ram_addr1    = cpu_addr;
      ram_wdata    = cpu_wdata;
      ram_mem_op   = cpu_mem_op;
      ram_ram_mask = cpu_ram_mask;
    end
  end

  assign cpu_hold      = (state_q != RUN);
  assign busy          = (state_q == LOAD) || (state_q == DRAIN);
  assign overflow      = overflow_q;
  assign words_written = words_q;

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Sits directly upstream of the rv32i RAM and owns its port 1 (addr1/wdata/mem_op/ram_mask).
- After reset it holds the CPU, accepts program words from the APF bridge (already synchronised to clk), buffers them in a small FIFO and stores them as aligned 32-bit words.
- Once loading ends and the FIFO has drained, it releases the CPU and passes the CPU's data-port signals straight through to the RAM.

Parameters:
- ADDR_BASE, 32'h0000_0000, bridge byte address that maps to RAM address 0.
- ADDR_LENGTH, 21, RAM byte-address width; must match the RAM instance.
- FIFO_DEPTH, 4, bridge-write buffer entries; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- load_start  in  1  single-cycle pulse: begin a load session.
- load_end  in  1  single-cycle pulse: the host has sent its last word.
- bridge_wr  in  1  single-cycle write strobe.
- bridge_addr  in  32  byte address of the write.
- bridge_wdata  in  32  write data.
- cpu_addr  in  32  CPU data address.
- cpu_wdata  in  32  CPU store data.
- cpu_mem_op  in  mem_op_e  CPU memory operation.
- cpu_ram_mask  in  ram_mask_e  CPU access size.
- ram_addr1  out  32  to RAM addr1.
- ram_wdata  out  32  to RAM wdata.
- ram_mem_op  out  mem_op_e  to RAM mem_op.
- ram_ram_mask  out  ram_mask_e  to RAM ram_mask.
- cpu_hold  out  1  high keeps the CPU in reset or stall.
- busy  out  1  high in LOAD or DRAIN.
- overflow  out  1  sticky: a bridge write was dropped.
- words_written  out  32  count of words stored this session.

Behaviour:
- Reset values:
  - State is HOLD; cpu_hold=1, busy=0, overflow=0, words_written=0.
  - FIFO is empty.
  - ram_mem_op=MEM_LOAD, ram_addr1=0, ram_wdata=0, ram_ram_mask=RAM_MASK_W.
- HOLD:
  - cpu_hold=1; bridge_wr is ignored.
  - load_start moves to LOAD.
  - load_end alone moves to RUN, so a boot without a load still runs.
- LOAD:
  - busy=1.
  - A bridge_wr with ADDR_BASE <= bridge_addr < ADDR_BASE + 2**ADDR_LENGTH pushes {offset word address, data}.
  - bridge_addr[1:0] is ignored; the entry is stored word-aligned.
  - Out-of-window writes are dropped silently and do not set overflow.
  - load_end moves to DRAIN; a write in the same cycle as load_end is still accepted.
- DRAIN:
  - busy=1; no new pushes.
  - When the FIFO is empty and no store is in flight, move to RUN.
- RUN:
  - cpu_hold=0, busy=0.
  - ram_* is a combinational pass-through of cpu_*.
  - bridge_wr is ignored; overflow is not set.
  - load_start returns to LOAD (cpu_hold=1 from the next cycle) and clears words_written and overflow.
- FIFO and store path:
  - When the FIFO is non-empty, one entry pops per cycle into registered ram_* outputs: mem_op=MEM_STORE, ram_mask=RAM_MASK_W.
  - A bridge_wr at cycle N appears as a store on the RAM port during cycle N+1 (empty FIFO) and is written at the end of N+1.
  - In any cycle without a pop, ram_mem_op=MEM_LOAD.
  - words_written increments on each pop and wraps at 2^32.
- Full FIFO:
  - A push and pop in the same cycle is accepted.
  - A push with no pop sets overflow and drops the word.
- Reset asserted mid-operation:
  - Immediately returns to HOLD and flushes the FIFO.
  - ram_mem_op goes to MEM_LOAD asynchronously, so no partial store is issued.

Optional Feature:
- Macro: RAM_LOADER_BSWAP_EN.
- Defined: bridge_wdata is byte-reversed before being pushed, i.e. {d[7:0], d[15:8], d[23:16], d[31:24]}. This converts the APF big-endian data stream to the RV32I little-endian layout.
- Undefined: data is stored unchanged.
- The macro has no other effect on behaviour or timing.

Decomposition:
- The rv32i package gains loader_state_e (HOLD, LOAD, DRAIN, RUN) and LOADER_FIFO_DEPTH_DEFAULT.
- mem_op_e and ram_mask_e are reused from the package unchanged.
- One sub-module: ram_loader_fifo, a synchronous FIFO with FIFO_DEPTH and WIDTH parameters and push, pop, full, empty, head outputs.

Test Plan:
- Reset, load_start, then writes 0x00000000<-0x11223344 and 0x00000004<-0x55667788, then load_end. Required:
  - RAM word0=0x11223344 and word1=0x55667788 (0x44332211 and 0x88776655 with BSWAP).
  - words_written=2.
  - cpu_hold falls 1 cycle after the FIFO empties.
- Five back-to-back bridge_wr with FIFO_DEPTH=4, starting from an empty FIFO. Required: all five are stored and overflow=0, because the pop overlaps the pushes.
- With the store path stalled by forcing a full FIFO via pop-gating in the bench, one extra write is issued. Required: overflow=1, that word is absent from RAM, and the other words are intact.
- Write to ADDR_BASE + 2**ADDR_LENGTH. Required: no store, words_written unchanged, overflow=0.
- Assert reset in the same cycle a store is presented, with 3 entries queued. Required: state=HOLD, RAM unchanged for the queued entries, cpu_hold=1.
- In RUN, CPU issues a byte store 0xAB at 0x0000_0101. Required: ram_* mirrors cpu_* and RAM byte 0x101=0xAB; a bridge_wr in the same cycle is ignored.
